// File: rtl/dma_priority_resolver.sv
// Four-channel DMA request arbiter: qualifies DREQ pins, resolves fixed or rotating
// priority and sequences grant -> acknowledge -> release toward timing & control.
module dma_priority_resolver #(
  parameter int NCH      = 4,
  parameter int ROT_INIT = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic           dreq_sense,
  input  logic           dack_sense,
  input  logic           rot_pri,
  input  logic           ctrl_disable,
  input  logic [NCH-1:0] mask,
  input  logic           hrq,
  input  logic           VALID_DACK,
  input  logic           eop,
  input  logic           timeout,
  output logic           VALID_DREQ0,
  output logic           VALID_DREQ1,
  output logic           VALID_DREQ2,
  output logic           VALID_DREQ3,
  output logic [NCH-1:0] DACK,
  output logic [1:0]     grant_ch,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SERVICE, S_RELEASE} state_t;

  state_t         r_state;
  logic [NCH-1:0] r_samp;
  logic [NCH-1:0] r_vld;
  logic [1:0]     r_grant_ch;
  logic [1:0]     r_low_ptr;
  logic           r_busy;

  logic [NCH-1:0] w_eff_req;
  logic [1:0]     w_base;
  logic [1:0]     w_cand;
  logic [1:0]     w_win;
  logic           w_found;
  logic [NCH-1:0] w_dack_act;

  function automatic logic [NCH-1:0] f_onehot(input logic [1:0] ch);
    logic [NCH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  assign w_eff_req = (r_samp ^ {NCH{dreq_sense}}) & ~mask;

  // Search starts at the highest-priority slot and wraps upward.
  assign w_base = rot_pri ? (r_low_ptr + 2'd1) : 2'd0;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cand = w_base + 2'(i);
      if (!w_found && w_eff_req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_samp     <= '0;
      r_vld      <= '0;
      r_grant_ch <= '0;
      r_low_ptr  <= 2'(ROT_INIT);
      r_busy     <= 1'b0;
    end else begin
      r_samp <= DREQ;
      case (r_state)
        S_IDLE: begin
          if (w_found && !ctrl_disable) begin
            r_grant_ch <= w_win;
            r_vld      <= f_onehot(w_win);
            r_busy     <= 1'b1;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (VALID_DACK) begin
            r_state <= S_SERVICE;
          end else if (!w_eff_req[r_grant_ch] || timeout) begin
            r_vld   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (eop || !w_eff_req[r_grant_ch] || !VALID_DACK) begin
            r_vld   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (rot_pri) r_low_ptr <= r_grant_ch;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // DACK is decoded from state so it drops with an asynchronous reset.
  assign w_dack_act = (r_state == S_SERVICE) ? f_onehot(r_grant_ch) : '0;
  assign DACK       = dack_sense ? w_dack_act : ~w_dack_act;

  assign VALID_DREQ0 = r_vld[0];
  assign VALID_DREQ1 = r_vld[1];
  assign VALID_DREQ2 = r_vld[2];
  assign VALID_DREQ3 = r_vld[3];
  assign grant_ch    = r_grant_ch;
  assign busy        = r_busy;

  a_hrq_in_service: assert property (@(posedge CLK) disable iff (!RESET)
    (r_state == S_SERVICE) |-> hrq);

endmodule
